// File: rtl/seg_scan_ctrl.sv
// Multiplexed N-digit 7-segment scanner: frame-synchronous double-buffered data,
// per-digit dp, leading-zero blanking, PWM brightness. Blink is built only with SEG_BLINK_EN.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIM_BITS     = 2,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                    CLK500Hz,
    input  logic                    rstn,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    lzb_en,
    input  logic [DIM_BITS-1:0]     bright,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic [7:0]              seg_n,
    output logic                    frame_start,
    output logic                    busy_pend
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {ST_START, ST_SCAN} state_t;
    state_t state, state_nxt;

    logic [DIM_BITS-1:0]        sub_cnt;
    logic [IDX_W-1:0]           digit_idx;
    logic [4*NUM_DIGITS-1:0]    pend_data, act_data;
    logic [NUM_DIGITS-1:0]      pend_dp, act_dp;
    logic [NUM_DIGITS-1:0]      blank;
    logic [NUM_DIGITS:0]        zrun;
    logic [NUM_DIGITS-1:0][7:0] pat;
    logic                       wrap, xfer, lit, dark_blink;

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        case (nib)
            4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
        endcase
    endfunction

    // ST_START holds the counters at 0 for one cycle so the first edge after reset is a frame start
    always_ff @(posedge CLK500Hz or negedge rstn) begin
        if (!rstn) state <= ST_START;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wrap      = 1'b0;
        case (state)
            ST_START: state_nxt = ST_SCAN;
            default:  wrap = (&sub_cnt) && (digit_idx == LAST_IDX);
        endcase
        xfer = (state == ST_START) || wrap;
    end

    // A digit is blanked while every digit from the top down to it is a bare zero
    assign zrun[NUM_DIGITS] = 1'b1;
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        assign zrun[g] = zrun[g+1] && (act_data[4*g +: 4] == 4'h0) && !act_dp[g];
        assign pat[g]  = {~act_dp[g], seg7(act_data[4*g +: 4])};
        if (g == 0) begin : g_lsd
            assign blank[g] = 1'b0;
        end else begin : g_msd
            assign blank[g] = lzb_en && zrun[g];
        end
    end

`ifdef SEG_BLINK_EN
    localparam int FC_W = $clog2(BLINK_FRAMES + 1);
    logic [FC_W-1:0] frame_cnt;
    logic            blink_phase;

    // The startup frame start is not counted, so the first phase lasts a full BLINK_FRAMES frames
    always_ff @(posedge CLK500Hz or negedge rstn) begin
        if (!rstn) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (wrap) begin
            if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + FC_W'(1);
            end
        end
    end
    assign dark_blink = blink_phase && blink_mask[digit_idx];
`else
    logic unused_blink;
    assign unused_blink = ^{blink_mask, BLINK_FRAMES[0]};
    assign dark_blink   = 1'b0;
`endif

    assign lit = (state == ST_SCAN) && (sub_cnt <= bright) && !blank[digit_idx] && !dark_blink;

    always_ff @(posedge CLK500Hz or negedge rstn) begin
        if (!rstn) begin
            sub_cnt     <= '0;
            digit_idx   <= '0;
            pend_data   <= '0;
            pend_dp     <= '0;
            act_data    <= '0;
            act_dp      <= '0;
            busy_pend   <= 1'b0;
            frame_start <= 1'b0;
            an_n        <= '1;
            seg_n       <= 8'hFF;
        end else begin
            if (state == ST_SCAN) begin
                sub_cnt <= sub_cnt + DIM_BITS'(1);
                if (&sub_cnt)
                    digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + IDX_W'(1);
            end
            // A load coinciding with the transfer lands in pending; the old pending is what moves
            if (xfer) begin
                act_data <= pend_data;
                act_dp   <= pend_dp;
            end
            if (load) begin
                pend_data <= data_in;
                pend_dp   <= dp_in;
            end
            busy_pend   <= load ? 1'b1 : (xfer ? 1'b0 : busy_pend);
            frame_start <= xfer;
            an_n        <= lit ? ~(NUM_DIGITS'(1) << digit_idx) : '1;
            seg_n       <= lit ? pat[digit_idx] : 8'hFF;
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: hex decode, dimming, blanking, frame-synced loads, reset, blink.
module tb_seg_scan_ctrl;
    localparam int ND = 4;
    localparam int DB = 2;
`ifdef SEG_BLINK_EN
    localparam int BF = 2;
`else
    localparam int BF = 32;
`endif

    logic          CLK500Hz = 1'b0;
    logic          rstn;
    logic [15:0]   data_in;
    logic [3:0]    dp_in;
    logic          load;
    logic          lzb_en;
    logic [1:0]    bright;
    logic [3:0]    blink_mask;
    logic [3:0]    an_n;
    logic [7:0]    seg_n;
    logic          frame_start;
    logic          busy_pend;

    int checks = 0;
    int errors = 0;
    logic [3:0] cap_an  [17];
    logic [7:0] cap_seg [17];
    logic       cap_fs  [17];

    seg_scan_ctrl #(.NUM_DIGITS(ND), .DIM_BITS(DB), .BLINK_FRAMES(BF)) dut (
        .CLK500Hz(CLK500Hz), .rstn(rstn), .data_in(data_in), .dp_in(dp_in), .load(load),
        .lzb_en(lzb_en), .bright(bright), .blink_mask(blink_mask), .an_n(an_n),
        .seg_n(seg_n), .frame_start(frame_start), .busy_pend(busy_pend)
    );

    always #5 CLK500Hz = ~CLK500Hz;

    task automatic wait_fs();
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge CLK500Hz);
            if (frame_start) got = 1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL wait_fs: frame_start not seen within 40 clocks");
        end
    endtask

    // Records the 16 clocks following a frame_start cycle; index k shows slot (k-1)
    task automatic capture();
        for (int k = 1; k <= 16; k++) begin
            @(negedge CLK500Hz);
            cap_an[k]  = an_n;
            cap_seg[k] = seg_n;
            cap_fs[k]  = frame_start;
        end
    endtask

    task automatic load_word(input logic [15:0] d, input logic [3:0] dp);
        wait_fs();
        @(negedge CLK500Hz);
        data_in = d; dp_in = dp; load = 1'b1;
        @(negedge CLK500Hz);
        load = 1'b0;
        checks++;
        if (busy_pend !== 1'b1) begin
            errors++; $display("FAIL load_busy: got %b want 1", busy_pend);
        end
        wait_fs();
        checks++;
        if (busy_pend !== 1'b0) begin
            errors++; $display("FAIL load_applied_busy: got %b want 0", busy_pend);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; data_in = '0; dp_in = '0; load = 1'b0; lzb_en = 1'b0;
        bright = 2'd3; blink_mask = '0;
        #12;
        checks++;
        if (an_n !== 4'hF || seg_n !== 8'hFF || frame_start !== 1'b0 || busy_pend !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: an_n=%h seg_n=%h fs=%b busy=%b want F FF 0 0",
                     an_n, seg_n, frame_start, busy_pend);
        end
        @(negedge CLK500Hz);
        rstn = 1'b1;
        @(negedge CLK500Hz);
        checks++;
        if (frame_start !== 1'b1 || an_n !== 4'hF) begin
            errors++;
            $display("FAIL reset_first_fs: fs=%b an_n=%h want 1 F", frame_start, an_n);
        end
    endtask

    task automatic test_hex();
        logic [7:0] exp_seg [4] = '{8'h8E, 8'h88, 8'hA4, 8'hF9};
        logic [3:0] exp_an;
        bright = 2'd3;
        load_word(16'h12AF, 4'h0);
        capture();
        for (int k = 1; k <= 16; k++) begin
            exp_an = ~(4'b0001 << ((k - 1) / 4));
            checks++;
            if (cap_an[k] !== exp_an || cap_seg[k] !== exp_seg[(k-1)/4] || cap_fs[k] !== (k == 16)) begin
                errors++;
                $display("FAIL hex_k%0d: an=%h seg=%h fs=%b want %h %h %b", k, cap_an[k],
                         cap_seg[k], cap_fs[k], exp_an, exp_seg[(k-1)/4], (k == 16));
            end
        end
    endtask

    task automatic test_dim();
        logic [3:0] exp_an;
        logic [7:0] exp_seg;
        bright = 2'd0;
        load_word(16'h8888, 4'h0);
        capture();
        for (int k = 1; k <= 16; k++) begin
            exp_an  = ((k - 1) % 4 == 0) ? ~(4'b0001 << ((k - 1) / 4)) : 4'hF;
            exp_seg = ((k - 1) % 4 == 0) ? 8'h80 : 8'hFF;
            checks++;
            if (cap_an[k] !== exp_an || cap_seg[k] !== exp_seg) begin
                errors++;
                $display("FAIL dim_k%0d: an=%h seg=%h want %h %h", k, cap_an[k], cap_seg[k],
                         exp_an, exp_seg);
            end
        end
        bright = 2'd3;
    endtask

    task automatic test_lzb();
        logic [7:0] exp_a [4] = '{8'hC0, 8'hB0, 8'hFF, 8'hFF};
        logic [7:0] exp_b [4] = '{8'hC0, 8'hB0, 8'h40, 8'hFF};
        logic [3:0] exp_an;
        lzb_en = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            load_word(16'h0030, (pass == 0) ? 4'b0000 : 4'b0100);
            capture();
            for (int k = 1; k <= 16; k += 3) begin
                logic [7:0] es;
                es     = (pass == 0) ? exp_a[(k-1)/4] : exp_b[(k-1)/4];
                exp_an = (es == 8'hFF) ? 4'hF : ~(4'b0001 << ((k - 1) / 4));
                checks++;
                if (cap_an[k] !== exp_an || cap_seg[k] !== es) begin
                    errors++;
                    $display("FAIL lzb_p%0d_k%0d: an=%h seg=%h want %h %h", pass, k,
                             cap_an[k], cap_seg[k], exp_an, es);
                end
            end
        end
        lzb_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit got = 0;
        wait_fs();
        @(negedge CLK500Hz); data_in = 16'h1111; dp_in = 4'h0; load = 1'b1;
        @(negedge CLK500Hz); load = 1'b0;
        @(negedge CLK500Hz); data_in = 16'h2222; load = 1'b1;
        @(negedge CLK500Hz); load = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge CLK500Hz);
            checks++;
            if (frame_start) begin
                got = 1;
                if (busy_pend !== 1'b0) begin
                    errors++; $display("FAIL b2b_busy_clear: got %b want 0", busy_pend);
                end
            end else if (busy_pend !== 1'b1 || seg_n === 8'hF9) begin
                errors++;
                $display("FAIL b2b_pending: busy=%b seg=%h want busy 1, seg not F9", busy_pend, seg_n);
            end
        end
        if (!got) begin
            checks++; errors++; $display("FAIL b2b_fs: frame_start not seen");
        end
        capture();
        for (int k = 1; k <= 16; k++) begin
            checks++;
            if (cap_seg[k] !== 8'hA4 || cap_an[k] !== ~(4'b0001 << ((k - 1) / 4))) begin
                errors++;
                $display("FAIL b2b_k%0d: an=%h seg=%h want seg A4", k, cap_an[k], cap_seg[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        wait_fs();
        repeat (9) @(negedge CLK500Hz);
        checks++;
        if (an_n !== 4'b1011 || seg_n !== 8'hA4) begin
            errors++; $display("FAIL rmid_pre: an=%h seg=%h want B A4", an_n, seg_n);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (an_n !== 4'hF || seg_n !== 8'hFF || busy_pend !== 1'b0 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async: an=%h seg=%h busy=%b fs=%b want F FF 0 0", an_n, seg_n,
                     busy_pend, frame_start);
        end
        @(negedge CLK500Hz);
        rstn = 1'b1;
        wait_fs();
        capture();
        for (int k = 1; k <= 16; k += 4) begin
            checks++;
            if (cap_an[k] !== ~(4'b0001 << ((k - 1) / 4)) || cap_seg[k] !== 8'hC0) begin
                errors++;
                $display("FAIL rmid_post_k%0d: an=%h seg=%h want seg C0", k, cap_an[k], cap_seg[k]);
            end
        end
    endtask

    task automatic test_blink();
        bit dark0;
`ifdef SEG_BLINK_EN
        blink_mask = 4'b0001;
`else
        blink_mask = 4'b1111;
`endif
        @(negedge CLK500Hz); rstn = 1'b0;
        @(negedge CLK500Hz); rstn = 1'b1;
        wait_fs();
        for (int f = 0; f < 4; f++) begin
            capture();
`ifdef SEG_BLINK_EN
            dark0 = (f >= 2);
`else
            dark0 = 1'b0;
`endif
            checks++;
            if (cap_an[1] !== (dark0 ? 4'hF : 4'hE) || cap_seg[1] !== (dark0 ? 8'hFF : 8'hC0)) begin
                errors++;
                $display("FAIL blink_d0_f%0d: an=%h seg=%h want dark=%b", f, cap_an[1], cap_seg[1], dark0);
            end
            checks++;
            if (cap_an[5] !== 4'hD || cap_seg[5] !== 8'hC0) begin
                errors++;
                $display("FAIL blink_d1_f%0d: an=%h seg=%h want D C0", f, cap_an[5], cap_seg[5]);
            end
        end
        blink_mask = '0;
    endtask

    initial begin
        test_reset();
        test_hex();
        test_dim();
        test_lzb();
        test_back_to_back();
        test_reset_mid();
        test_blink();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Parametrised N-digit multiplexed 7-segment scan controller for the board display path; drives active-low anode and segment lines.
- Adds features beyond a fixed 4-digit hex scanner:
  - double-buffered data load, applied only at frame boundaries
  - per-digit decimal point
  - leading-zero blanking
  - PWM brightness control
  - optional blink
- Sits between the RNG result registers and the display pins.

Parameters:
- NUM_DIGITS, 4, digits scanned; range 2..8.
- DIM_BITS, 2, brightness resolution; each digit slot lasts 2^DIM_BITS clocks.
- BLINK_FRAMES, 32, frames per blink half-period; only used with SEG_BLINK_EN.

Ports:
- CLK500Hz  in  1  scan clock; all logic on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- data_in  in  4*NUM_DIGITS  hex nibbles; nibble 0 (LSBs) is the rightmost digit.
- dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit.
- load  in  1  single-cycle strobe; captures data_in/dp_in into the pending buffer.
- lzb_en  in  1  leading-zero blanking enable.
- bright  in  DIM_BITS  brightness level, 0 = dimmest, max = full on.
- blink_mask  in  NUM_DIGITS  digits that blink (SEG_BLINK_EN only).
- an_n  out  NUM_DIGITS  anode selects, active-low, one-hot-zero.
- seg_n  out  8  {dp,g,f,e,d,c,b,a}, active-low.
- frame_start  out  1  one-cycle pulse on the first clock of digit 0's slot.
- busy_pend  out  1  pending buffer holds data not yet applied.

Behaviour:
- Reset (async):
  - an_n = all 1, seg_n = 8'hFF, frame_start = 0, busy_pend = 0.
  - digit index = 0, sub-slot counter = 0, active and pending buffers = 0, blink phase = 0.
- Counters:
  - sub_cnt (DIM_BITS wide) increments every clock.
  - When sub_cnt wraps from max to 0, digit_idx increments, wrapping NUM_DIGITS-1 -> 0.
  - Frame length = NUM_DIGITS * 2^DIM_BITS clocks (16 with defaults).
- Outputs are registered, with 1-clock latency from counter state. With sub_cnt = s and digit_idx = i on cycle t, on cycle t+1:
  - If s <= bright and the digit is not blanked: an_n[i] = 0, all other anodes 1, seg_n = pattern.
  - Otherwise: an_n = all 1 and seg_n = 8'hFF.
  - At bright = max the digit is lit for all 2^DIM_BITS clocks; at bright = 0 it is lit for 1 clock.
- Segment pattern (seg_n[6:0]), hex:
  - 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8
  - 8:80, 9:90, A:88, b:83, C:C6, d:A1, E:86, F:8E
  - seg_n[7] = ~dp of that digit.
- Load and frame sync:
  - load copies data_in/dp_in into pending and sets busy_pend.
  - On the cycle where digit_idx goes to 0 and sub_cnt = 0, pending is copied to active and busy_pend clears.
  - frame_start is asserted in that same cycle.
  - load on the same cycle as the transfer: the new value goes to pending, busy_pend stays 1, and the old pending value is transferred.
  - Back-to-back loads: last one wins.
  - The display never shows a mix of two loads within one frame.
- Leading-zero blanking (lzb_en = 1):
  - Scanning from digit NUM_DIGITS-1 downward, digits whose active nibble = 0 and dp = 0 are blanked until the first non-zero nibble or set dp.
  - Digit 0 is never blanked.
  - Blanking is evaluated on the active buffer.
- bright and lzb_en are sampled continuously; a change takes effect on the next output update.
- Reset mid-frame: everything returns to reset values immediately. Scanning restarts at digit 0 on the first edge after rstn rises; that first cycle is a frame_start.

Optional Feature:
- SEG_BLINK_EN defined:
  - A frame counter toggles blink_phase every BLINK_FRAMES frames; the toggle happens at frame_start.
  - While blink_phase = 1, digits with blink_mask[i] = 1 are forced dark: an_n[i] stays 1 and seg_n = FF during their slot.
- SEG_BLINK_EN not defined:
  - blink_mask is ignored and no frame counter is built.
  - Output is identical to the blink-enabled build with blink_mask = 0.

Test Plan:
- Reset, then load data_in = 16'h12AF, dp_in = 0, bright = 3.
  - After the next frame_start: per 4-clock slot, digit0 an_n = 1110 with seg_n = 8E; digit1 = 88; digit2 = A4; digit3 = F9.
  - frame_start period is 16 clocks.
- bright = 0, data_in = 16'h8888:
  - Each anode is low exactly 1 clock of 4, with seg_n = 80.
  - For the remaining 3 clocks an_n = 1111 and seg_n = FF.
- lzb_en = 1, data_in = 16'h0030:
  - digits 3 and 2 are blank; digit 1 = B0; digit 0 = C0.
  - Same with dp_in = 4'b0100: digit 2 shows seg_n = 40 (dp with 0); digit 3 stays blank.
- load 16'h1111, then load 16'h2222 two cycles later, both mid-frame:
  - busy_pend = 1 until the next frame_start.
  - The whole next frame shows 2s; no 1s ever appear.
- Assert rstn = 0 mid-slot of digit 2: an_n = 1111 and seg_n = FF immediately (asynchronous).
  - After release, the first lit digit is digit 0 and active data = 0 (seg_n = C0).
- SEG_BLINK_EN with BLINK_FRAMES = 2, blink_mask = 4'b0001:
  - Digit 0 is lit for 2 frames, dark for 2 frames, repeating.
  - Other digits are unaffected.
